out_port_allocator: RTL and testbench
=====================================

Name: out_port_allocator

Overview:
- Switch/VC allocator for one output port of the 5-port, 2-VC wormhole router.
- Each cycle it picks at most one (input port, VC) requester to drive the output link, using fair round-robin.
- Each output VC stays locked to its owning input from the head flit until the tail flit, so packets never interleave on a VC.
- The router instantiates one per output port. GNT/SEL drive the crossbar mux for ODATA_n/OVALID_n/OVCH_n, and OLCK feeds the router's lock signalling.

Parameters:
- NUM_IN, 5, number of input ports.
- NUM_VC, 2, number of virtual channels. VC is preserved across the router (input VC v maps to output VC v).
- IDX_W, 3, width of the input-port index (clog2(NUM_IN)).

Ports:
- clk  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  NUM_IN*NUM_VC  request vector. Bit r = in*NUM_VC+vc: the flit at the head of input `in`, VC `vc`, is routed to this output.
- TAIL  input  NUM_IN*NUM_VC  bit r: requester r's current flit is a tail (a single-flit packet has both head and tail).
- VC_RDY  input  NUM_VC  downstream VC has buffer space for one flit this cycle.
- GNT  output  NUM_IN*NUM_VC  one-hot or zero. The flit of the granted requester is transferred this cycle.
- GNT_VLD  output  1  OR of GNT; drives OVALID.
- SEL_IN  output  IDX_W  crossbar select, input index of the winner (0 when no grant).
- SEL_VC  output  1  VC of the winner; drives OVCH (0 when no grant).
- OLCK  output  NUM_VC  bit v is high while output VC v is owned by a packet in flight.

Behaviour:
- GNT, GNT_VLD, SEL_IN and SEL_VC are combinational from REQ/TAIL/VC_RDY and the registered state. Zero-latency grant; all state updates on the next rising clk.
- Registered state:
  - per-VC lock FSM;
  - owner index per VC (IDX_W bits);
  - round-robin pointer ptr over 0..NUM_IN*NUM_VC-1.
- Reset (RST=1 at clk edge): every VC FREE, owners 0, ptr 0, OLCK 0. While RST=1, GNT/GNT_VLD/SEL_IN/SEL_VC are forced to 0.
- Eligibility of requester r (in = r/NUM_VC, vc = r%NUM_VC) requires all of:
  - REQ[r];
  - VC_RDY[vc];
  - (state[vc]==FREE) or (state[vc]==OWNED and owner[vc]==in).
- Arbitration:
  - At most one grant per cycle (single physical link).
  - Winner is the first eligible requester scanning r = ptr, ptr+1, ... with wrap from NUM_IN*NUM_VC-1 to 0.
  - No eligible requester: GNT=0, state and ptr unchanged.
- Pointer update on a grant to r: ptr <= (r+1) mod NUM_IN*NUM_VC. Wrap: r=9 gives ptr=0.
- Lock FSM per VC v, states FREE and OWNED:
  - FREE -> OWNED(owner=in) on a grant to r with vc==v and TAIL[r]=0.
  - FREE stays FREE on a grant with TAIL[r]=1 (single-flit packet).
  - OWNED -> FREE on a grant to the owner with TAIL[r]=1. Release takes effect next cycle; another input cannot win v in the same cycle as the tail.
  - OWNED stays OWNED while the owner has no REQ or VC_RDY[v]=0. No timeout; the other VC keeps arbitrating normally.
- OLCK[v] = (state[v]==OWNED), registered.
- TAIL bits of non-granted requesters are ignored.
- RST asserted mid-packet drops all locks immediately. Upstream is reset by the same RST.
- Invariant: GNT one-hot or zero, and never asserted to a requester that was not eligible.

Decomposition:
- Shared package router_pkg:
  - NUM_IN, NUM_VC, IDX_W, NUM_REQ (= NUM_IN*NUM_VC);
  - lock state enum {FREE, OWNED};
  - function for requester-index to (in, vc) split.
- One sub-module rr_arbiter, parameterized N:
  - inputs: eligible vector, ptr;
  - outputs: one-hot grant, encoded index;
  - purely combinational rotate/priority/rotate-back.
- Lock FSMs, owner registers and ptr register live in out_port_allocator.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then REQ=0.
  -> GNT=0, GNT_VLD=0, SEL_IN=0, SEL_VC=0, OLCK=00.
- Single-flit packet: REQ[4]=1 (in2, vc0), TAIL[4]=1, VC_RDY=11.
  -> GNT=0x010, SEL_IN=2, SEL_VC=0 that cycle; OLCK stays 00; ptr=5 next cycle.
- Wormhole lock: in1/vc1 (r=3) sends head/body/tail (TAIL=0,0,1) while in3/vc1 (r=7) requests continuously.
  -> r=3 granted 3 consecutive cycles; OLCK[1]=1 from cycle 2 to cycle 3; r=7 first granted in cycle 4.
- VC independence: vc0 locked to in0 and in0 stalled (REQ[0]=0); REQ[5]=1 (in2, vc1), VC_RDY=11.
  -> GNT=0x020, OLCK[0] remains 1.
- Backpressure: owner of vc1 requesting, VC_RDY=01.
  -> no grant on vc1, lock held; vc0 requesters still granted.
- Round-robin fairness and wrap: all 10 REQ high, TAIL all 1, VC_RDY=11, ptr=0.
  -> grants r=0,1,...,9,0 on successive cycles; ptr wraps 9->0.
- Reset mid-packet: assert RST while OLCK=01.
  -> next cycle OLCK=00, ptr=0; after RST deassert, a new head from any input can win vc0.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared router sizes, VC lock state and requester-index split
package router_pkg;
  localparam int NUM_IN = 5;
  localparam int NUM_VC = 2;
  localparam int IDX_W = 3;
  localparam int VC_W = 1;
  localparam int NUM_REQ = NUM_IN * NUM_VC;
  localparam int REQ_W = $clog2(NUM_REQ);
  typedef enum logic {FREE, OWNED} lock_e;
  typedef struct packed {
    logic [IDX_W-1:0] in;
    logic [VC_W-1:0] vc;
  } req_split_t;
  function automatic req_split_t split_req(input logic [REQ_W-1:0] r);
    split_req.in = IDX_W'(r / REQ_W'(NUM_VC));
    split_req.vc = VC_W'(r % REQ_W'(NUM_VC));
  endfunction
endpackage

// File: rtl/out_port_allocator_if.sv
// out_port_allocator_if: requests in, grant/crossbar select and VC locks out
interface out_port_allocator_if;
  import router_pkg::*;
  logic [NUM_REQ-1:0] REQ;
  logic [NUM_REQ-1:0] TAIL;
  logic [NUM_VC-1:0] VC_RDY;
  logic [NUM_REQ-1:0] GNT;
  logic GNT_VLD;
  logic [IDX_W-1:0] SEL_IN;
  logic SEL_VC;
  logic [NUM_VC-1:0] OLCK;
  modport master (output REQ, TAIL, VC_RDY, input GNT, GNT_VLD, SEL_IN, SEL_VC, OLCK);
  modport slave (input REQ, TAIL, VC_RDY, output GNT, GNT_VLD, SEL_IN, SEL_VC, OLCK);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible bit at or after ptr
module rr_arbiter #(
  parameter int N = 10,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  localparam logic [W:0] NW = (W+1)'(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0] sum;
  logic hit;
  // rotate so ptr is bit 0, take the lowest set bit, rotate the index back
  always_comb begin
    dbl = {elig, elig} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = W'(i);
        hit = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = hit ? (sum >= NW ? W'(sum - NW) : W'(sum)) : '0;
    gnt = hit ? ONE << idx : '0;
  end
endmodule

// File: rtl/out_port_allocator.sv
// out_port_allocator: round-robin switch/VC allocator with per-VC wormhole locks
module out_port_allocator
  import router_pkg::*;
(
  input logic clk,
  input logic RST,
  out_port_allocator_if.slave bus
);
  lock_e state_q [NUM_VC];
  lock_e state_d [NUM_VC];
  logic [IDX_W-1:0] owner_q [NUM_VC];
  logic [IDX_W-1:0] owner_d [NUM_VC];
  logic [REQ_W-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0] elig, arb_gnt;
  logic [REQ_W-1:0] arb_idx;
  req_split_t s, win;
  // a requester may compete only if its VC has space and is free or already held by its input
  always_comb begin
    s = '0;
    elig = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      s = split_req(REQ_W'(r));
      elig[r] = bus.REQ[r] & bus.VC_RDY[s.vc] & (state_q[s.vc] == FREE || owner_q[s.vc] == s.in);
    end
  end
  rr_arbiter #(.N(NUM_REQ), .W(REQ_W)) u_arb (
    .elig(elig),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );
  // grant outputs (forced idle in reset) and lock/owner/pointer next state
  always_comb begin
    win = split_req(arb_idx);
    bus.GNT = RST ? '0 : arb_gnt;
    bus.GNT_VLD = |bus.GNT;
    bus.SEL_IN = bus.GNT_VLD ? win.in : '0;
    bus.SEL_VC = bus.GNT_VLD ? win.vc : 1'b0;
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    for (int v = 0; v < NUM_VC; v++) bus.OLCK[v] = state_q[v] == OWNED;
    if (bus.GNT_VLD) begin
      ptr_d = arb_idx == REQ_W'(NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
      state_d[win.vc] = bus.TAIL[arb_idx] ? FREE : OWNED;
      owner_d[win.vc] = win.in;
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= '{default: FREE};
      owner_q <= '{default: '0};
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_out_port_allocator.sv
// tb_out_port_allocator: directed checks of grant, locking, fairness and reset
module tb_out_port_allocator;
  logic clk = 1'b0;
  logic RST = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  out_port_allocator_if bus ();
  out_port_allocator dut (.clk(clk), .RST(RST), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [9:0] req, input logic [9:0] tail, input logic [1:0] rdy);
    bus.REQ = req;
    bus.TAIL = tail;
    bus.VC_RDY = rdy;
    #2;
  endtask
  task automatic chk_out(input string tag, input logic [9:0] gnt, input logic [2:0] sin, input logic svc);
    chk({tag, ".gnt"}, 32'(bus.GNT), 32'(gnt));
    chk({tag, ".vld"}, 32'(bus.GNT_VLD), 32'(|gnt));
    chk({tag, ".sel_in"}, 32'(bus.SEL_IN), 32'(sin));
    chk({tag, ".sel_vc"}, 32'(bus.SEL_VC), 32'(svc));
  endtask
  initial begin
    drive(10'h3ff, 10'h3ff, 2'b11);
    chk_out("rst_force", 10'h000, 3'd0, 1'b0);
    tick();
    tick();
    RST = 1'b0;
    drive(10'h000, 10'h000, 2'b11);
    chk_out("idle", 10'h000, 3'd0, 1'b0);
    chk("idle.olck", 32'(bus.OLCK), 32'h0);
    drive(10'h010, 10'h010, 2'b11);
    chk_out("single", 10'h010, 3'd2, 1'b0);
    tick();
    drive(10'h000, 10'h000, 2'b11);
    chk("single.olck", 32'(bus.OLCK), 32'h0);
    chk("single.ptr", 32'(dut.ptr_q), 32'd5);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drive(10'h088, 10'h080, 2'b11);
    chk_out("worm1", 10'h008, 3'd1, 1'b1);
    chk("worm1.olck", 32'(bus.OLCK), 32'h0);
    tick();
    drive(10'h088, 10'h080, 2'b11);
    chk_out("worm2", 10'h008, 3'd1, 1'b1);
    chk("worm2.olck", 32'(bus.OLCK), 32'h2);
    tick();
    drive(10'h088, 10'h088, 2'b11);
    chk_out("worm3", 10'h008, 3'd1, 1'b1);
    chk("worm3.olck", 32'(bus.OLCK), 32'h2);
    tick();
    drive(10'h080, 10'h080, 2'b11);
    chk_out("worm4", 10'h080, 3'd3, 1'b1);
    chk("worm4.olck", 32'(bus.OLCK), 32'h0);
    tick();
    drive(10'h001, 10'h000, 2'b11);
    chk_out("vc0_head", 10'h001, 3'd0, 1'b0);
    tick();
    drive(10'h030, 10'h030, 2'b11);
    chk_out("vc_indep", 10'h020, 3'd2, 1'b1);
    chk("vc_indep.olck", 32'(bus.OLCK), 32'h1);
    tick();
    drive(10'h008, 10'h000, 2'b11);
    chk_out("vc1_head", 10'h008, 3'd1, 1'b1);
    tick();
    chk("both.olck", 32'(bus.OLCK), 32'h3);
    drive(10'h009, 10'h001, 2'b01);
    chk_out("bp_vc0", 10'h001, 3'd0, 1'b0);
    tick();
    drive(10'h008, 10'h000, 2'b01);
    chk_out("bp_hold", 10'h000, 3'd0, 1'b0);
    chk("bp_hold.olck", 32'(bus.OLCK), 32'h2);
    tick();
    drive(10'h080, 10'h080, 2'b11);
    chk_out("locked_out", 10'h000, 3'd0, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(10'h3ff, 10'h3ff, 2'b11);
      chk($sformatf("rr%0d", i), 32'(bus.GNT), 32'(1) << i);
      tick();
    end
    chk("rr.wrap_ptr", 32'(dut.ptr_q), 32'd0);
    drive(10'h3ff, 10'h3ff, 2'b11);
    chk_out("rr10", 10'h001, 3'd0, 1'b0);
    tick();
    drive(10'h004, 10'h000, 2'b11);
    chk_out("mid_head", 10'h004, 3'd1, 1'b0);
    tick();
    chk("mid.olck", 32'(bus.OLCK), 32'h1);
    RST = 1'b1;
    #2;
    chk("mid_rst.gnt", 32'(bus.GNT), 32'h0);
    tick();
    chk("mid_rst.olck", 32'(bus.OLCK), 32'h0);
    chk("mid_rst.ptr", 32'(dut.ptr_q), 32'd0);
    RST = 1'b0;
    drive(10'h010, 10'h000, 2'b11);
    chk_out("post_rst", 10'h010, 3'd2, 1'b0);
    tick();
    chk("post_rst.olck", 32'(bus.OLCK), 32'h1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
